// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with HI/LO registers.
// Multi-cycle MULT/MULTU/DIV/DIVU with a fixed busy window, single-cycle
// MTHI/MTLO, and zero-latency MFHI/MFLO reads.
// Optional feature macro: E_MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (accumulate into {hi,lo} at commit time).
//
// state | meaning
// IDLE  | no op in flight; accepts start, MTHI/MTLO write hi/lo directly
// RUN   | op in flight; cnt counts down, pending result commits when cnt hits 0
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [3:0]  mduOp,
  input  logic        start,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] mduResult
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam logic [4:0] MULT_LAT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LAT  = 5'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} stateT;

  stateT       state, stateNext;
  logic [4:0]  cnt, cntNext;
  logic [31:0] hi, lo, hiN, loN;

  logic        isMulOp, isDivOp, isSigned;
  logic        accept, launch, commit, writeHi, writeLo;
  logic [63:0] extA, extB, prod, pending;
  logic        negA, negB, divZero;
  logic [31:0] magA, magB, divisor, quotU, remU, quot, rem;

`ifdef E_MDU_MADD_EN
  // accMode: 0 plain load, 1 accumulate-add, 2 accumulate-subtract
  logic [1:0]  accMode, accModeNext;
  logic [63:0] accSum, accDiff;
`endif

  // Opcode classification; MADD family only counts as a multiply when enabled.
  always_comb begin
    isMulOp = (mduOp == OP_MULT) || (mduOp == OP_MULTU);
`ifdef E_MDU_MADD_EN
    isMulOp = isMulOp || ((mduOp >= OP_MADD) && (mduOp <= OP_MSUBU));
    if ((mduOp == OP_MSUB) || (mduOp == OP_MSUBU))
      accModeNext = 2'd2;
    else if (mduOp >= OP_MADD)
      accModeNext = 2'd1;
    else
      accModeNext = 2'd0;
`endif
    isDivOp  = (mduOp == OP_DIV) || (mduOp == OP_DIVU);
    isSigned = (mduOp == OP_MULT) || (mduOp == OP_DIV) ||
               (mduOp == OP_MADD) || (mduOp == OP_MSUB);
  end

  assign accept  = (state == IDLE) && start && !flush;
  assign launch  = accept && (isMulOp || isDivOp);
  assign writeHi = accept && (mduOp == OP_MTHI);
  assign writeLo = accept && (mduOp == OP_MTLO);
  assign commit  = (state == RUN) && (cnt <= 5'd1) && !flush;
  assign busy    = (state == RUN);

  // Full 64-bit product; the low 64 bits of the extended operands' product
  // are the correct signed or unsigned result.
  always_comb begin
    extA = isSigned ? {{32{srcA[31]}}, srcA} : {32'd0, srcA};
    extB = isSigned ? {{32{srcB[31]}}, srcB} : {32'd0, srcB};
    prod = extA * extB;
  end

  // Divide on magnitudes and fix signs afterwards, so 0x80000000 / -1 wraps
  // instead of relying on a native signed divide. Divisor is forced nonzero.
  always_comb begin
    negA    = isSigned && srcA[31];
    negB    = isSigned && srcB[31];
    magA    = negA ? (~srcA + 32'd1) : srcA;
    magB    = negB ? (~srcB + 32'd1) : srcB;
    divZero = (srcB == 32'd0);
    divisor = divZero ? 32'd1 : magB;
    quotU   = magA / divisor;
    remU    = magA % divisor;
    quot    = (negA ^ negB) ? (~quotU + 32'd1) : quotU;
    rem     = negA ? (~remU + 32'd1) : remU;
  end

  // Value captured into hiN/loN at launch; divide by zero re-captures hi/lo.
  always_comb begin
    if (isDivOp)
      pending = divZero ? {hi, lo} : {rem, quot};
    else
      pending = prod;
  end

`ifdef E_MDU_MADD_EN
  assign accSum  = {hi, lo} + {hiN, loN};
  assign accDiff = {hi, lo} - {hiN, loN};
`endif

  // FSM state and countdown register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state: load latency on launch, count down in RUN, flush aborts.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (launch) begin
          stateNext = RUN;
          cntNext   = isDivOp ? DIV_LAT : MULT_LAT;
        end
      end
      RUN: begin
        if (flush || (cnt <= 5'd1)) begin
          stateNext = IDLE;
          cntNext   = 5'd0;
        end else begin
          cntNext = cnt - 5'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 5'd0;
      end
    endcase
  end

  // HI/LO and pending-result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi  <= 32'd0;
      lo  <= 32'd0;
      hiN <= 32'd0;
      loN <= 32'd0;
`ifdef E_MDU_MADD_EN
      accMode <= 2'd0;
`endif
    end else begin
      if (launch) begin
        {hiN, loN} <= pending;
`ifdef E_MDU_MADD_EN
        accMode <= accModeNext;
`endif
      end
      if (commit) begin
`ifdef E_MDU_MADD_EN
        case (accMode)
          2'd1:    {hi, lo} <= accSum;
          2'd2:    {hi, lo} <= accDiff;
          default: {hi, lo} <= {hiN, loN};
        endcase
`else
        {hi, lo} <= {hiN, loN};
`endif
      end else begin
        if (writeHi) hi <= srcA;
        if (writeLo) lo <= srcA;
      end
    end
  end

  // Zero-latency HI/LO read port.
  always_comb begin
    case (mduOp)
      OP_MFHI: mduResult = hi;
      OP_MFLO: mduResult = lo;
      default: mduResult = 32'd0;
    endcase
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the pipelined MIPS core. It sits beside the ALU in E and receives the same forwarded operands `srcA`/`srcB`. It runs signed and unsigned multiply and divide over multiple cycles, holds the HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. It exports `busy` so the hazard unit can stall D-stage multiply/divide instructions.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (and MADD-family when enabled); legal range 1–31.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1–31.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `srcA`  in  32  operand rs, forwarded value.
- `srcB`  in  32  operand rt, forwarded value.
- `mduOp`  in  4  operation code:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
  - 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
  - 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU
  - 13–15 treated as NONE.
- `start`  in  1  qualifies `mduOp` 1–4, 7–12 for this cycle.
- `flush`  in  1  cancels the in-flight op (exception/interrupt in E).
- `busy`  out  1  a multi-cycle op is in progress.
- `mduResult`  out  32  HI for MFHI, LO for MFLO, else 0.

## Operation
- Internal state:
  - `hi`, `lo`: 32 bits each.
  - Down-counter `cnt`: 5 bits.
  - Pending result regs `hiN`, `loN`.
  - FSM {IDLE, RUN}.
- Reset (async, `rst_n`=0): `hi`=`lo`=0, `cnt`=0, FSM=IDLE, `busy`=0, `hiN`=`loN`=0. Reset mid-operation aborts the op; it leaves no residue.
- IDLE + `start` + MULT/MULTU/DIV/DIVU (+MADD family when enabled):
  - Compute the full result combinationally from `srcA`/`srcB` captured at that edge; store it in `hiN`/`loN`.
  - Load `cnt` with the latency; go to RUN.
- Operand results:
  - MULT: {hi,lo} = $signed(A)*$signed(B).
  - MULTU: unsigned 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (`srcB`=0, DIV/DIVU): timing is unchanged and `busy` runs the full DIV_CYCLES, but `hi`/`lo` keep their old values at completion.
- RUN: `cnt` decrements each cycle. On the edge where `cnt` goes 1→0:
  - commit `hiN`/`loN` to `hi`/`lo`
  - return to IDLE.
- MTHI/MTLO with `start` in IDLE: `hi`/`lo` := `srcA` at that edge. Single cycle; `busy` stays 0.
- MFHI/MFLO: purely combinational read of the current `hi`/`lo`. No `start` required.
- `start` while RUN: ignored; in-flight op continues. Hazard unit guarantees this does not happen; the RTL still must not corrupt state.
- `flush`=1 in RUN: next state IDLE, `cnt`=0, `hi`/`lo` unchanged.
- `flush` with `start` in the same cycle: flush wins; the op is not started and MTHI/MTLO do not write.
- `start` with NONE/MFHI/MFLO/13–15: no state change.
- Signed DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).

## Timing
- `busy` is registered:
  - `start` at edge T (MULT) → `busy`=1 during cycles T+1 … T+MULT_CYCLES.
  - `hi`/`lo` new from cycle T+MULT_CYCLES+1; `busy`=0 that cycle.
  - DIV is identical with DIV_CYCLES.
- A new `start` is accepted in the first cycle `busy`=0. Back-to-back ops have no bubble beyond the busy window.
- MTHI/MTLO at edge T: visible on `mduResult` (MFHI/MFLO) from cycle T+1.
- `mduResult` is valid the same cycle `mduOp` is presented (zero latency).
- Stall contract for the hazard unit: stall a D-stage MDU instruction whenever `busy`=1 or E holds an accepted multi-cycle `start`.

## Configuration
- `E_MDU_MADD_EN` defined:
  - MADD/MADDU: {hi,lo} += signed/unsigned product.
  - MSUB/MSUBU: {hi,lo} −= signed/unsigned product.
  - Each takes MULT_CYCLES; the accumulate uses `hi`/`lo` as of commit time.
- Not defined: opcodes 9–12 are treated as NONE; no accumulator adder is synthesised.

## Test plan
- Reset, then MULT A=0xFFFFFFFF B=2 → `busy` high exactly 5 cycles; MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFE.
- MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7 B=0 → `busy` 10 cycles; hi/lo unchanged.
- MTHI 0x12345678 then MFHI next cycle → 0x12345678. MTLO issued with `flush`=1 → lo unchanged.
- Start MULT, assert `flush` in busy cycle 3 → `busy` drops next cycle; hi/lo hold their prior values. Start DIV, pulse `rst_n` low in cycle 4 → hi=lo=0 and `busy`=0 immediately.
- With `E_MDU_MADD_EN`: hi=0, lo=0xFFFFFFFF, MADDU A=1 B=1 → hi=1, lo=0. Without the macro, the same op leaves hi/lo unchanged and `busy`=0.
